// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared FSM encoding and default constants for the clock divider monitor
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_STUCK   = 2'd3
  } mon_state_e;

  localparam int DEF_CNT_W      = 8;
  localparam int DEF_EXP_PERIOD = 12;
  localparam int DEF_EXP_HIGH   = 6;
  localparam int DEF_LOCK_COUNT = 4;

endpackage

// File: rtl/clk_div_monitor_if.sv
// rtl/clk_div_monitor_if.sv - measurement/status bundle driven by the monitor
interface clk_div_monitor_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             meas_valid;
  logic             locked;
  logic             err;
  logic             timeout;

  modport master (output period_o, high_o, meas_valid, locked, err, timeout);
  modport slave  (input  period_o, high_o, meas_valid, locked, err, timeout);
endinterface

// File: rtl/clk_edge_sync.sv
// rtl/clk_edge_sync.sv - two-flop synchronizer plus one-flop delay yielding rise/fall/level strobes
module clk_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o,
  output logic level_o
);
  logic [1:0] sync_q;
  logic       dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      dly_q  <= sync_q[1];
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~dly_q;
  assign fall_o  = ~sync_q[1] & dly_q;
endmodule

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - measures period/high time of a divided clock and tracks lock/stuck status
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int EXP_HIGH   = DEF_EXP_HIGH,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_in,
  clk_div_monitor_if.master  mon
);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

  mon_state_e       state_q, state_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] cnt_q, period_q, high_q;
  logic             meas_valid_q, err_q;
  logic             rise, fall, level;
  logic             sat, hit;
  logic             measuring, locked_c, timeout_c;
  logic             unused_level;

  clk_edge_sync u_sync (
    .clk     (clk),
    .rst_n   (rst),
    .d_i     (clk_in),
    .rise_o  (rise),
    .fall_o  (fall),
    .level_o (level)
  );
  assign unused_level = level;

  assign sat = (cnt_q == {CNT_W{1'b1}});
  assign hit = (cnt_q == CNT_W'(EXP_PERIOD)) && (high_q == CNT_W'(EXP_HIGH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  // A rise always takes priority over saturation in the same cycle.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MEASURE;
        end else if (sat) begin
          state_d = ST_STUCK;
          match_d = '0;
        end
      end
      ST_MEASURE, ST_LOCKED: begin
        if (rise) begin
          if (!hit) begin
            state_d = ST_MEASURE;
            match_d = '0;
          end else if (state_q == ST_MEASURE) begin
            match_d = match_q + MATCH_W'(1);
            if (match_q == MATCH_W'(LOCK_COUNT - 1)) state_d = ST_LOCKED;
          end
        end else if (sat) begin
          state_d = ST_STUCK;
          match_d = '0;
        end
      end
      ST_STUCK: begin
        if (rise) state_d = ST_MEASURE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    measuring = 1'b0;
    locked_c  = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      ST_MEASURE: measuring = 1'b1;
      ST_LOCKED: begin
        measuring = 1'b1;
        locked_c  = 1'b1;
      end
      ST_STUCK: timeout_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (rise)      cnt_q <= CNT_W'(1);
      else if (!sat) cnt_q <= cnt_q + CNT_W'(1);
      if (fall) high_q <= cnt_q;
      if (rise && measuring) period_q <= cnt_q;
      meas_valid_q <= rise & measuring;
      err_q        <= rise & measuring & ~hit;
    end
  end

  assign mon.period_o   = period_q;
  assign mon.high_o     = high_q;
  assign mon.meas_valid = meas_valid_q;
  assign mon.err        = err_q;
  assign mon.locked     = locked_c;
  assign mon.timeout    = timeout_c;
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - directed and randomized clk_in waveforms against an event-level lock model
module tb_clk_div_monitor;
  logic clk;
  logic rst;
  logic clk_in;

  clk_div_monitor_if #(.CNT_W(8)) mon ();

  clk_div_monitor dut (
    .clk    (clk),
    .rst    (rst),
    .clk_in (clk_in),
    .mon    (mon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a rise compares the previous whole period against the expectation.
  bit have_ref;
  int streak;
  int exp_period;
  int last_high;
  int prev_per;
  int prev_hi;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    have_ref   = 1'b0;
    streak     = 0;
    exp_period = 0;
    last_high  = 0;
    prev_per   = 0;
    prev_hi    = 0;
  endtask

  // One clk_in period starting with a rise at the current falling clk edge.
  task automatic drive(int hi, int per);
    bit mis;
    bit upd;
    upd = have_ref;
    mis = 1'b0;
    if (upd) begin
      exp_period = prev_per;
      mis = !(prev_per == 12 && prev_hi == 6);
      streak = mis ? 0 : streak + 1;
    end else begin
      streak = 0;
    end
    for (int t = 0; t < per; t++) begin
      if (t == 0)  clk_in = 1'b1;
      if (t == hi) clk_in = 1'b0;
      if (t == 3) begin
        chk("meas_valid@rise", 32'(mon.meas_valid), 32'(upd));
        chk("err@rise",        32'(mon.err),        32'(upd & mis));
        chk("period_o@rise",   32'(mon.period_o),   32'(exp_period));
        chk("high_o@rise",     32'(mon.high_o),     32'(last_high));
        chk("locked@rise",     32'(mon.locked),     32'(streak >= 4));
        chk("timeout@rise",    32'(mon.timeout),    32'd0);
      end
      if (t == 4) begin
        chk("meas_valid_pulse", 32'(mon.meas_valid), 32'd0);
        chk("err_pulse",        32'(mon.err),        32'd0);
      end
      @(negedge clk);
    end
    if (per <= 255 || per >= 258) begin
      chk("timeout@end", 32'(mon.timeout), 32'(per >= 258));
      chk("locked@end",  32'(mon.locked),  32'(streak >= 4 && per <= 255));
    end
    if (per > 255) begin
      have_ref = 1'b0;
      streak   = 0;
    end else begin
      have_ref = 1'b1;
    end
    prev_per  = per;
    prev_hi   = hi;
    last_high = hi;
  endtask

  initial begin
    int per;
    int hi;
    rst    = 1'b1;
    clk_in = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    #1;
    chk("reset_period", 32'(mon.period_o),   32'd0);
    chk("reset_high",   32'(mon.high_o),     32'd0);
    chk("reset_valid",  32'(mon.meas_valid), 32'd0);
    chk("reset_locked", 32'(mon.locked),     32'd0);
    chk("reset_err",    32'(mon.err),        32'd0);
    chk("reset_tmo",    32'(mon.timeout),    32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    repeat (5) drive(6, 12);
    chk("locked_after_5", 32'(mon.locked), 32'd1);

    drive(6, 13);
    repeat (5) drive(6, 12);
    chk("relocked", 32'(mon.locked), 32'd1);

    drive(7, 12);
    repeat (5) drive(6, 12);

    drive(6, 300);
    repeat (6) drive(6, 12);

    // Asynchronous reset while locked, away from any clock edge.
    #2 rst = 1'b0;
    #1;
    chk("midlock_locked", 32'(mon.locked),     32'd0);
    chk("midlock_period", 32'(mon.period_o),   32'd0);
    chk("midlock_high",   32'(mon.high_o),     32'd0);
    chk("midlock_valid",  32'(mon.meas_valid), 32'd0);
    chk("midlock_err",    32'(mon.err),        32'd0);
    chk("midlock_tmo",    32'(mon.timeout),    32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) drive(6, 12);

    drive(6, 255);
    repeat (3) drive(6, 12);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) per = int'($urandom_range(5, 40));
      else                           per = 12;
      if (per == 12 && $urandom_range(0, 3) != 0) hi = 6;
      else                                        hi = int'($urandom_range(1, per - 1));
      drive(hi, per);
    end
    drive(6, 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/clk_div_monitor.md
CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of all cycle counters and measurement outputs.
REQ-002 SHALL have parameter EXP_PERIOD, default 12, expected clk_in period in clk cycles.
REQ-003 SHALL have parameter EXP_HIGH, default 6, expected clk_in high time in clk cycles.
REQ-004 SHALL have parameter LOCK_COUNT, default 4, consecutive matching periods required for lock.
REQ-005 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port clk_in  input  1  divided clock under test, asynchronous to clk.
REQ-008 SHALL have port period_o  output  CNT_W  last measured rise-to-rise period in clk cycles.
REQ-009 SHALL have port high_o  output  CNT_W  last measured rise-to-fall high time in clk cycles.
REQ-010 SHALL have port meas_valid  output  1  one-cycle pulse when period_o/high_o update.
REQ-011 SHALL have port locked  output  1  high while in LOCKED state.
REQ-012 SHALL have port err  output  1  one-cycle pulse on a period or duty mismatch.
REQ-013 SHALL have port timeout  output  1  level; high while in STUCK state.

Function
REQ-014 SHALL pass clk_in through a 2-flop synchronizer, then a 1-flop delay; rise = sync & ~delayed, fall = ~sync & delayed.
REQ-015 SHALL increment cnt every cycle, saturating at 2^CNT_W-1; on rise SHALL load cnt to 1.
REQ-016 On fall SHALL capture high_o <= cnt (high time H yields H).
REQ-017 On rise in MEASURE or LOCKED SHALL set period_o <= cnt and pulse meas_valid the next cycle; outputs register 3 clk cycles after the clk_in edge reaches the synchronizer.
REQ-018 FSM states: IDLE, MEASURE, LOCKED, STUCK.
REQ-019 IDLE: first rise -> MEASURE; no period_o update, no meas_valid, no err.
REQ-020 MEASURE: rise with cnt==EXP_PERIOD and high_o==EXP_HIGH increments match_cnt; when match_cnt reaches LOCK_COUNT -> LOCKED.
REQ-021 MEASURE or LOCKED: rise with either value mismatching SHALL pulse err, clear match_cnt, go to MEASURE, deasserting locked the cycle after the mismatch.
REQ-022 Any state except STUCK: cnt saturating SHALL go to STUCK and clear match_cnt; timeout is high in STUCK.
REQ-023 STUCK: next rise -> MEASURE with cnt reloaded; no period_o update for that rise.
REQ-024 Rise and saturation in the same cycle: rise wins.
REQ-025 A fall with no preceding rise since reset SHALL still update high_o; it is only checked at the next rise.

Reset
REQ-026 On rst low, asynchronously: state=IDLE, cnt=0, match_cnt=0, synchronizer and delay flops=0, period_o=0, high_o=0, meas_valid=0, locked=0, err=0, timeout=0.
REQ-027 Reset mid-lock SHALL drop locked immediately and require LOCK_COUNT fresh matches after the first post-reset rise.

Structure
REQ-028 FSM state encoding and default parameter constants SHALL live in shared package clk_div_pkg.
REQ-029 The synchronizer plus edge detector SHALL be sub-module clk_edge_sync, outputs rise/fall/level.

Verification
REQ-030 clk_in period 12, high 6 (output of the divide block) -> after 1st rise MEASURE; locked=1 after the 5th rise; period_o=12, high_o=6, err never set.
REQ-031 Locked, one period stretched to 13 cycles -> period_o=13, err pulse, locked=0; relocks after 4 further good periods.
REQ-032 Locked, high time 7 with period 12 -> high_o=7, err pulse, locked=0.
REQ-033 clk_in held low for 300 cycles -> timeout=1 when cnt reaches 255, locked=0; next rise -> timeout=0, state MEASURE.
REQ-034 rst pulsed low while locked -> all outputs 0 asynchronously; lock reacquired only after 1+LOCK_COUNT rises.
REQ-035 Rise coincident with cnt saturation (period 255) -> no timeout; period_o=255, err pulse.
